inamp_sar_readout: RTL



---
 rtl/inamp_sar_pkg.sv | 20 ++
 rtl/inamp_cmp_sync.sv | 22 ++
 rtl/inamp_sar_readout.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/inamp_sar_pkg.sv
// Shared types and constants for the instrumentation-amplifier SAR readout.
package inamp_sar_pkg;

    localparam int unsigned WIDTH_DEF         = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned GAIN_BITS_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Autogain steps the gain up when a result falls below 2^(width-3).
    function automatic int unsigned autogain_low(input int unsigned width);
        return (width >= 3) ? (32'd1 << (width - 3)) : 32'd1;
    endfunction

endpackage

// File: rtl/inamp_cmp_sync.sv
// Two-flop synchroniser for the asynchronous comparator output.
module inamp_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: two back-to-back flops, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inamp_sar_readout.sv
// SAR conversion controller for the instrumentation-amplifier front end.
// Optional automatic gain ranging is built when INAMP_AUTOGAIN_EN is defined.
module inamp_sar_readout
    import inamp_sar_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned GAIN_BITS     = GAIN_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [GAIN_BITS-1:0] gain_cfg,
    input  logic                 cmp_in,
    output logic [WIDTH-1:0]     dac_code,
    output logic                 track,
    output logic [GAIN_BITS-1:0] gain_sel,
    output logic                 busy,
    output logic [WIDTH-1:0]     result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] bit_idx;
    logic             cmp_sync;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] kept_code;
`ifdef INAMP_AUTOGAIN_EN
    logic             gain_init;
`endif

    inamp_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    // Trial decision: keep the bit under test if the comparator says amp >= DAC.
    always_comb begin
        bit_mask  = WIDTH'(1) << bit_idx;
        kept_code = cmp_sync ? dac_code : (dac_code & ~bit_mask);
    end

    // Conversion sequencer with registered analog-side and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            bit_idx      <= '0;
            dac_code     <= '0;
            track        <= 1'b0;
            gain_sel     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef INAMP_AUTOGAIN_EN
            gain_init    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (start && ena) begin
                        state    <= SAMPLE;
                        busy     <= 1'b1;
                        track    <= 1'b1;
                        dac_code <= '0;
`ifdef INAMP_AUTOGAIN_EN
                        if (!gain_init) begin
                            gain_sel  <= gain_cfg;
                            gain_init <= 1'b1;
                        end
`else
                        gain_sel <= gain_cfg;
`endif
                    end
                end
                SAMPLE: begin
                    if (!ena) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        track    <= 1'b0;
                        dac_code <= '0;
                        count    <= '0;
                    end else if (count == CNT_LAST) begin
                        state    <= CONVERT;
                        track    <= 1'b0;
                        bit_idx  <= IDX_MSB;
                        dac_code <= MSB_CODE;
                        count    <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (!ena) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        track    <= 1'b0;
                        dac_code <= '0;
                        count    <= '0;
                    end else if (count == CNT_LAST) begin
                        count <= '0;
                        if (bit_idx == '0) begin
                            result       <= kept_code;
                            dac_code     <= kept_code;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            dac_code <= kept_code | (bit_mask >> 1);
                            bit_idx  <= bit_idx - IDX_W'(1);
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
`ifdef INAMP_AUTOGAIN_EN
                        if ((&result) && (gain_sel != '0)) begin
                            gain_sel <= gain_sel - GAIN_BITS'(1);
                        end else if ((32'(result) < autogain_low(WIDTH)) && (gain_sel != '1)) begin
                            gain_sel <= gain_sel + GAIN_BITS'(1);
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
